i2c_write_sequencer: RTL

//  Sequences the I2C master for complete register-write transactions:

---
 rtl/i2c_write_sequencer.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_write_sequencer.sv
// Sequences an I2C master through one register write: START, device address (W),
// register pointer, cmd_len data bytes, STOP. Optional per-phase watchdog: I2C_TIMEOUT_EN.
module i2c_write_sequencer #(
    parameter int LEN_W          = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TO_W           = 17
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [6:0]       i_cmd_dev_addr,
    input  logic [7:0]       i_cmd_reg_addr,
    input  logic [LEN_W-1:0] i_cmd_len,
    input  logic [7:0]       i_wdata,
    input  logic             i_wdata_valid,
    output logic             o_wdata_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_m_i2c_en,
    output logic             o_m_start,
    output logic             o_m_wr_en,
    output logic             o_m_stop,
    output logic [7:0]       o_m_tx_data,
    input  logic             i_m_ready,
    input  logic             i_m_hold,
    input  logic             i_m_tx_done
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_SEND_ADDR = 4'd1;
    localparam logic [3:0] S_WAIT_ADDR = 4'd2;
    localparam logic [3:0] S_SEND_REG  = 4'd3;
    localparam logic [3:0] S_WAIT_REG  = 4'd4;
    localparam logic [3:0] S_SEND_DATA = 4'd5;
    localparam logic [3:0] S_WAIT_DATA = 4'd6;
    localparam logic [3:0] S_STOP      = 4'd7;
    localparam logic [3:0] S_WAIT_IDLE = 4'd8;

    logic [3:0]       r_state;
    logic [6:0]       r_dev_addr;
    logic [7:0]       r_reg_addr;
    logic [LEN_W-1:0] r_len;
    logic             r_busy;
    logic             r_done;
    logic             r_m_start;
    logic             r_m_stop;
    logic             r_wdata_ready;
    logic [7:0]       r_m_tx_data;

    logic [3:0]       w_state_nxt;
    logic             w_cmd_ready;
    logic             w_accept;
    logic             w_send;
    logic             w_take;
    logic             w_stop;
    logic             w_finish;
    logic             w_abort;
    logic [7:0]       w_tx_byte;

`ifdef I2C_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_abort;
    logic            r_err;
    logic            w_to_inc;
    logic            w_to_hit;

    // The watchdog is frozen while the data source has nothing to offer.
    assign w_to_inc = (r_state != S_IDLE) &&
                      ((r_state != S_SEND_DATA) || i_wdata_valid);
    assign w_to_hit = w_to_inc && (r_to_cnt == TO_LAST);
`endif

    assign w_cmd_ready = (r_state == S_IDLE) && i_m_ready && !i_rst;
    assign w_accept    = i_cmd_valid && w_cmd_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_send      = 1'b0;
        w_take      = 1'b0;
        w_stop      = 1'b0;
        w_finish    = 1'b0;
        w_abort     = 1'b0;
        w_tx_byte   = r_m_tx_data;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SEND_ADDR;
                end
            end
            S_SEND_ADDR: begin
                if (i_m_ready) begin
                    w_send      = 1'b1;
                    w_tx_byte   = {r_dev_addr, 1'b0};
                    w_state_nxt = S_WAIT_ADDR;
                end
            end
            S_WAIT_ADDR: begin
                if (i_m_tx_done) begin
                    w_state_nxt = S_SEND_REG;
                end
            end
            S_SEND_REG: begin
                if (i_m_hold) begin
                    w_send      = 1'b1;
                    w_tx_byte   = r_reg_addr;
                    w_state_nxt = S_WAIT_REG;
                end
            end
            S_WAIT_REG, S_WAIT_DATA: begin
                if (i_m_tx_done) begin
                    w_state_nxt = (r_len != '0) ? S_SEND_DATA : S_STOP;
                end
            end
            S_SEND_DATA: begin
                if (i_m_hold && i_wdata_valid) begin
                    w_send      = 1'b1;
                    w_take      = 1'b1;
                    w_tx_byte   = i_wdata;
                    w_state_nxt = S_WAIT_DATA;
                end
            end
            S_STOP: begin
                if (i_m_hold) begin
                    w_stop      = 1'b1;
                    w_state_nxt = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                // m_ready sampled alongside the m_stop pulse may be stale.
                if (i_m_ready && !r_m_stop) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
`ifdef I2C_TIMEOUT_EN
        if (w_to_hit && (w_state_nxt == r_state)) begin
            w_abort = 1'b1;
            if (r_state == S_WAIT_IDLE) begin
                w_finish    = 1'b1;
                w_state_nxt = S_IDLE;
            end else if (i_m_hold) begin
                w_state_nxt = S_STOP;
            end else begin
                w_state_nxt = S_WAIT_IDLE;
            end
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_m_start     <= 1'b0;
            r_m_stop      <= 1'b0;
            r_wdata_ready <= 1'b0;
            r_m_tx_data   <= 8'h00;
        end else begin
            r_state       <= w_state_nxt;
            r_done        <= w_finish;
            r_m_start     <= w_send;
            r_m_stop      <= w_stop;
            r_wdata_ready <= w_take;
            r_m_tx_data   <= w_tx_byte;
            if (w_accept) begin
                r_busy <= 1'b1;
                r_len  <= i_cmd_len;
            end else begin
                if (w_finish) begin
                    r_busy <= 1'b0;
                end
                if (w_take) begin
                    r_len <= r_len - LEN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_dev_addr <= i_cmd_dev_addr;
            r_reg_addr <= i_cmd_reg_addr;
        end
    end

`ifdef I2C_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_to_cnt <= '0;
            r_abort  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_to_cnt <= '0;
            end else if (w_to_inc) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            if (w_accept) begin
                r_abort <= 1'b0;
            end else if (w_abort) begin
                r_abort <= 1'b1;
            end
            r_err <= w_finish && (r_abort || w_abort);
        end
    end

    assign o_err = r_err;
`else
    logic [31:0] w_unused_cfg;
    assign w_unused_cfg = 32'(TIMEOUT_CYCLES + TO_W);
    assign o_err        = 1'b0;
`endif

    assign o_cmd_ready   = w_cmd_ready;
    assign o_wdata_ready = r_wdata_ready;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_m_i2c_en    = r_busy;
    assign o_m_start     = r_m_start;
    assign o_m_wr_en     = r_m_start;
    assign o_m_stop      = r_m_stop;
    assign o_m_tx_data   = r_m_tx_data;

endmodule
